// File: rtl/mdu_pkg.sv
// Shared types and constants for the per-core multiply/divide thread arbiter.
package mdu_pkg;

    localparam int NTHR  = 4;
    localparam int TID_W = 2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } mdu_state_e;

    function automatic logic [NTHR-1:0] tid_onehot(input logic [TID_W-1:0] tid);
        return {{(NTHR-1){1'b0}}, 1'b1} << tid;
    endfunction

endpackage

// File: rtl/mdu_thr_arb_if.sv
// Issue/return handshake between the thread arbiter and the shared mul/div unit.
interface mdu_thr_arb_if;
    import mdu_pkg::*;

    logic             issue_vld;
    logic [TID_W-1:0] issue_tid;
    logic             issue_div;
    logic             unit_ack;
    logic             unit_done;

    modport master (output issue_vld, issue_tid, issue_div, input unit_ack, unit_done);
    modport slave  (input issue_vld, issue_tid, issue_div, output unit_ack, unit_done);
endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker; the search starts at ptr and wraps.
module rr_arb4
    import mdu_pkg::*;
(
    input  logic [NTHR-1:0]  req,
    input  logic [TID_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [TID_W-1:0] gnt_tid
);

    logic [NTHR-1:0]  rot_s;
    logic [TID_W-1:0] off_s;

    // rotate requests so bit 0 is the thread at ptr
    always_comb begin
        rot_s = {NTHR{1'b0}};
        for (int i = 0; i < NTHR; i++) begin
            rot_s[i] = req[TID_W'(ptr + TID_W'(i))];
        end
    end

    // lowest rotated offset wins
    always_comb begin
        gnt_vld = 1'b1;
        off_s   = 2'd0;
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else if (rot_s[3]) begin
            off_s = 2'd3;
        end else begin
            off_s   = 2'd0;
            gnt_vld = 1'b0;
        end
    end

    assign gnt_tid = ptr + off_s;

endmodule

// File: rtl/mdu_thr_arb.sv
// Shares one non-pipelined mul/div unit among the core's threads: one queued op
// per thread, round-robin issue, flush-aware result return.
module mdu_thr_arb
    import mdu_pkg::*;
#(
    parameter int NTHR = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [NTHR-1:0]  mul_req,
    input  logic [NTHR-1:0]  div_req,
    input  logic [NTHR-1:0]  thr_flush,
    mdu_thr_arb_if.master    unit,
    output logic [NTHR-1:0]  mul_wait,
    output logic [NTHR-1:0]  div_wait,
    output logic [NTHR-1:0]  mul_busy_e,
    output logic [NTHR-1:0]  div_busy_e,
    output logic             done_vld,
    output logic [TID_W-1:0] done_tid,
    output logic             req_err
);

    mdu_state_e       state_r, state_nxt_s;
    logic [NTHR-1:0]  pend_mul_r, pend_div_r, pend_mul_nxt_s, pend_div_nxt_s;
    logic [NTHR-1:0]  arb_req_s, mul_busy_r, div_busy_r;
    logic [TID_W-1:0] rr_ptr_r, rr_ptr_nxt_s, tid_r, tid_nxt_s, gnt_tid_s, done_tid_r;
    logic             div_r, div_nxt_s, kill_r, kill_nxt_s, gnt_vld_s;
    logic             err_nxt_s, done_nxt_s, fin_s, own_flush_s;
    logic             issue_vld_r, done_vld_r, req_err_r;

    // a thread being flushed this cycle is not a candidate for the unit
    assign arb_req_s   = (pend_mul_r | pend_div_r) & ~thr_flush;
    assign own_flush_s = thr_flush[tid_r];
    assign fin_s       = (state_r == ST_BUSY) && unit.unit_done;

    rr_arb4 u_rr_arb4 (
        .req     (arb_req_s),
        .ptr     (rr_ptr_r),
        .gnt_vld (gnt_vld_s),
        .gnt_tid (gnt_tid_s)
    );

    // per-thread pending bits and illegal-request detection
    always_comb begin
        pend_mul_nxt_s = pend_mul_r;
        pend_div_nxt_s = pend_div_r;
        err_nxt_s      = 1'b0;
        for (int t = 0; t < NTHR; t++) begin
            if (thr_flush[t]) begin
                pend_mul_nxt_s[t] = 1'b0;
                pend_div_nxt_s[t] = 1'b0;
            end else if ((mul_req[t] || div_req[t]) && (pend_mul_r[t] || pend_div_r[t])) begin
                err_nxt_s = 1'b1;
                if (fin_s && !kill_r && (tid_r == TID_W'(t))) begin
                    pend_mul_nxt_s[t] = 1'b0;
                    pend_div_nxt_s[t] = 1'b0;
                end else begin
                    pend_mul_nxt_s[t] = pend_mul_r[t];
                end
            end else if (fin_s && !kill_r && (tid_r == TID_W'(t))) begin
                pend_mul_nxt_s[t] = 1'b0;
                pend_div_nxt_s[t] = 1'b0;
            end else if (mul_req[t]) begin
                pend_mul_nxt_s[t] = 1'b1;
                err_nxt_s         = err_nxt_s | div_req[t];
            end else if (div_req[t]) begin
                pend_div_nxt_s[t] = 1'b1;
            end else begin
                pend_mul_nxt_s[t] = pend_mul_r[t];
            end
        end
    end

    // issue sequencer: next state, issue target, kill tracking
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        tid_nxt_s    = tid_r;
        div_nxt_s    = div_r;
        kill_nxt_s   = kill_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                kill_nxt_s = 1'b0;
                if (gnt_vld_s) begin
                    state_nxt_s  = ST_ISSUE;
                    tid_nxt_s    = gnt_tid_s;
                    div_nxt_s    = pend_div_r[gnt_tid_s];
                    rr_ptr_nxt_s = gnt_tid_s + 2'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // a flush marks the op dead but the issue is still held until ack
                kill_nxt_s = kill_r | own_flush_s;
                if (unit.unit_ack) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (unit.unit_done) begin
                    state_nxt_s = ST_IDLE;
                    kill_nxt_s  = 1'b0;
                    done_nxt_s  = !(kill_r || own_flush_s);
                end else begin
                    kill_nxt_s = kill_r | own_flush_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                kill_nxt_s  = 1'b0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r     <= ST_IDLE;
            pend_mul_r  <= 4'b0000;
            pend_div_r  <= 4'b0000;
            rr_ptr_r    <= 2'd0;
            tid_r       <= 2'd0;
            div_r       <= 1'b0;
            kill_r      <= 1'b0;
            issue_vld_r <= 1'b0;
            mul_busy_r  <= 4'b0000;
            div_busy_r  <= 4'b0000;
            done_vld_r  <= 1'b0;
            done_tid_r  <= 2'd0;
            req_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pend_mul_r  <= pend_mul_nxt_s;
            pend_div_r  <= pend_div_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            tid_r       <= tid_nxt_s;
            div_r       <= div_nxt_s;
            kill_r      <= kill_nxt_s;
            issue_vld_r <= (state_nxt_s == ST_ISSUE);
            mul_busy_r  <= ((state_nxt_s != ST_IDLE) && (div_nxt_s == OP_MUL)) ? tid_onehot(tid_nxt_s) : 4'b0000;
            div_busy_r  <= ((state_nxt_s != ST_IDLE) && (div_nxt_s == OP_DIV)) ? tid_onehot(tid_nxt_s) : 4'b0000;
            done_vld_r  <= done_nxt_s;
            done_tid_r  <= done_nxt_s ? tid_r : 2'd0;
            req_err_r   <= err_nxt_s;
        end
    end

    assign unit.issue_vld = issue_vld_r;
    assign unit.issue_tid = tid_r;
    assign unit.issue_div = div_r;
    assign mul_wait       = pend_mul_r;
    assign div_wait       = pend_div_r;
    assign mul_busy_e     = mul_busy_r;
    assign div_busy_e     = div_busy_r;
    assign done_vld       = done_vld_r;
    assign done_tid       = done_tid_r;
    assign req_err        = req_err_r;

endmodule

// File: tb/tb_mdu_thr_arb.sv
// Directed scenarios plus random traffic, checked cycle by cycle against a
// transaction-level model of thread ownership of the shared unit.
module tb_mdu_thr_arb;
    import mdu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] mul_req, div_req, thr_flush;
    logic [3:0] mul_wait, div_wait, mul_busy_e, div_busy_e;
    logic       done_vld, req_err;
    logic [1:0] done_tid;

    always #5 clk = ~clk;

    mdu_thr_arb_if u_if ();

    mdu_thr_arb #(.NTHR(4)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .mul_req    (mul_req),
        .div_req    (div_req),
        .thr_flush  (thr_flush),
        .unit       (u_if.master),
        .mul_wait   (mul_wait),
        .div_wait   (div_wait),
        .mul_busy_e (mul_busy_e),
        .div_busy_e (div_busy_e),
        .done_vld   (done_vld),
        .done_tid   (done_tid),
        .req_err    (req_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: which thread owns the unit and whether it has been accepted
    logic [3:0] m_pm, m_pd;
    int         m_owner;
    logic       m_div, m_acked, m_killed, m_err, m_done_vld;
    int         m_rr, m_done_tid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_issue_vld();
        return (m_owner >= 0) && !m_acked;
    endfunction

    function automatic logic [3:0] exp_busy(input logic want_div);
        logic [3:0] one;
        one = 4'b0001;
        if (m_owner >= 0 && m_div == want_div) return one << m_owner;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_pm = 4'b0000; m_pd = 4'b0000; m_owner = -1; m_div = 1'b0;
        m_acked = 1'b0; m_killed = 1'b0; m_err = 1'b0; m_done_vld = 1'b0;
        m_rr = 0; m_done_tid = 0;
    endtask

    task automatic model_step(input logic [3:0] mr, dr, fl, input logic ack, done);
        logic [3:0] npm, npd;
        int w, t;
        npm = m_pm; npd = m_pd; m_err = 1'b0; m_done_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fl[i]) begin
                npm[i] = 1'b0; npd[i] = 1'b0;
            end else begin
                if ((mr[i] || dr[i]) && (m_pm[i] || m_pd[i])) m_err = 1'b1;
                else if (mr[i]) begin npm[i] = 1'b1; if (dr[i]) m_err = 1'b1; end
                else if (dr[i]) npd[i] = 1'b1;
                if (m_owner == i && m_acked && done && !m_killed) begin
                    npm[i] = 1'b0; npd[i] = 1'b0;
                end
            end
        end
        if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                t = (m_rr + k) % 4;
                if (w < 0 && (m_pm[t] || m_pd[t]) && !fl[t]) w = t;
            end
            if (w >= 0) begin
                m_owner = w; m_div = m_pd[w]; m_acked = 1'b0; m_killed = 1'b0;
                m_rr = (w + 1) % 4;
            end
        end else if (!m_acked) begin
            if (fl[m_owner]) m_killed = 1'b1;
            if (ack) m_acked = 1'b1;
        end else if (done) begin
            m_done_vld = !(m_killed || fl[m_owner]);
            m_done_tid = m_owner;
            m_owner = -1; m_killed = 1'b0; m_acked = 1'b0;
        end else if (fl[m_owner]) begin
            m_killed = 1'b1;
        end
        m_pm = npm; m_pd = npd;
    endtask

    task automatic check_outputs();
        check_eq("req_err", req_err, m_err);
        check_eq("done_vld", done_vld, m_done_vld);
        if (m_done_vld) check_eq("done_tid", done_tid, m_done_tid);
        check_eq("issue_vld", u_if.issue_vld, exp_issue_vld());
        if (exp_issue_vld()) begin
            check_eq("issue_tid", u_if.issue_tid, m_owner);
            check_eq("issue_div", u_if.issue_div, m_div);
        end
        check_eq("mul_wait", mul_wait, m_pm);
        check_eq("div_wait", div_wait, m_pd);
        check_eq("mul_busy_e", mul_busy_e, exp_busy(1'b0));
        check_eq("div_busy_e", div_busy_e, exp_busy(1'b1));
    endtask

    task automatic tick(input logic [3:0] mr, dr, fl, input logic ack, done);
        @(negedge clk);
        mul_req = mr; div_req = dr; thr_flush = fl;
        u_if.unit_ack = ack; u_if.unit_done = done;
        model_step(mr, dr, fl, ack, done);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // idle traffic; unit acks immediately and finishes lat cycles after accept
    task automatic drain(input int n, input int lat);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cnt = (m_owner >= 0 && m_acked) ? cnt + 1 : 0;
            tick(4'b0000, 4'b0000, 4'b0000, exp_issue_vld(), cnt >= lat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mul_req = 4'b0000; div_req = 4'b0000; thr_flush = 4'b0000;
        u_if.unit_ack = 1'b0; u_if.unit_done = 1'b0;
        #2 rst_l = 1'b0;
        #1;
        check_eq("rst_issue_vld", u_if.issue_vld, 1'b0);
        check_eq("rst_mul_wait", mul_wait, 4'b0000);
        check_eq("rst_div_wait", div_wait, 4'b0000);
        check_eq("rst_mul_busy", mul_busy_e, 4'b0000);
        check_eq("rst_div_busy", div_busy_e, 4'b0000);
        check_eq("rst_done_vld", done_vld, 1'b0);
        check_eq("rst_req_err", req_err, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        logic [3:0] mr, dr, fl;
        logic       ack, done;
        rst_l = 1'b0;
        mul_req = 4'b0000; div_req = 4'b0000; thr_flush = 4'b0000;
        u_if.unit_ack = 1'b0; u_if.unit_done = 1'b0;
        model_reset();
        do_reset();

        // single multiply, done 5 cycles after issue
        tick(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drain(3, 3);

        // all threads divide; round-robin order with bubbles
        tick(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        drain(30, 3);

        // illegal requests
        tick(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
        tick(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drain(10, 2);

        // flush of the busy thread, another thread waiting
        tick(4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        drain(10, 2);

        // ack withheld while another thread requests
        tick(4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drain(16, 2);

        // reset in the middle of a busy operation
        tick(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        do_reset();
        tick(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_eq("post_rst_vld", u_if.issue_vld, 1'b1);
        check_eq("post_rst_tid", u_if.issue_tid, 2'd3);
        drain(8, 2);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            for (int t = 0; t < 4; t++) begin
                mr[t] = ($urandom % 8) == 0;
                dr[t] = ($urandom % 8) == 0;
                fl[t] = ($urandom % 24) == 0;
            end
            ack  = exp_issue_vld() ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
            done = (m_owner >= 0 && m_acked) ? (($urandom % 4) == 0) : (($urandom % 12) == 0);
            tick(mr, dr, fl, ack, done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_thr_arb.md
# mdu_thr_arb

Per-core arbiter and sequencer that shares one non-pipelined multiply/divide unit among the four hardware threads of a core. It queues at most one outstanding mul or div operation per thread and grants the unit round-robin. It drives the unit through a valid/ack issue handshake and a done return. It also produces the per-thread `mul_wait`/`div_wait` masks and the `mul_busy_e`/`div_busy_e` flags consumed by thread-switch logic and the wait-mask monitors.

## Interface
Parameters:
- `NTHR`, 4, thread count; only 4 is supported.

Ports:
- `clk`  in  1  core clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `mul_req`  in  4  per-thread multiply request, one-cycle pulse.
- `div_req`  in  4  per-thread divide request, one-cycle pulse.
- `thr_flush`  in  4  per-thread flush; cancels that thread's operation.
- `unit_ack`  in  1  unit accepted the current issue.
- `unit_done`  in  1  unit finished the in-flight operation (one-cycle pulse).
- `issue_vld`  out  1  issue request to the unit.
- `issue_tid`  out  2  thread of the issued operation.
- `issue_div`  out  1  1 = divide, 0 = multiply.
- `mul_wait`  out  4  thread has a multiply pending or in flight.
- `div_wait`  out  4  thread has a divide pending or in flight.
- `mul_busy_e`  out  4  one-hot; thread owning the unit for a multiply.
- `div_busy_e`  out  4  one-hot; thread owning the unit for a divide.
- `done_vld`  out  1  result valid for `done_tid` (one-cycle pulse).
- `done_tid`  out  2  thread receiving the result.
- `req_err`  out  1  pulse; a request was dropped as illegal.

## Operation
- Per-thread state: `pend_mul[t]`, `pend_div[t]`, `kill`. Outputs `mul_wait = pend_mul`, `div_wait = pend_div`; a bit stays set until done or flush.
- Accepting a request: set `pend_mul[t]` or `pend_div[t]` if the thread has neither bit set.
- `req_err` pulses next cycle on any of the following. The offending request is dropped.
  - A request from a thread already pending or in flight.
  - `mul_req[t]` and `div_req[t]` in the same cycle; mul is accepted, div is dropped.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - If any thread is pending and not in flight, pick a winner round-robin, starting from `rr_ptr`.
  - Register `issue_tid`/`issue_div`, go to ISSUE, and set `rr_ptr` to winner+1 mod 4.
- ISSUE:
  - `issue_vld` is 1 and held stable until `unit_ack`.
  - On `unit_ack`, go to BUSY.
- BUSY:
  - On `unit_done`, pulse `done_vld`/`done_tid` the next cycle, clear the thread's pend bit, and go to IDLE.
- `mul_busy_e`/`div_busy_e` are decoded from `issue_tid`/`issue_div` in ISSUE and BUSY, and are 0 in IDLE.
- Flush of a thread that is only pending: clear its pend bits next cycle.
- Flush of the thread in ISSUE/BUSY:
  - Set `kill`. `issue_vld` is never dropped before ack.
  - The pend bit clears immediately.
  - At `unit_done`, `done_vld` is suppressed, and the FSM returns to IDLE normally.
- Flush and request for the same thread in the same cycle: flush wins and the request is dropped, with no `req_err`.
- Reset values (any time, including mid-operation): all outputs 0, FSM IDLE, `rr_ptr` 0, `kill` 0.

## Timing
- Request at cycle N → wait bit visible at N+1.
- In IDLE, arbitration happens at N+1 and `issue_vld` rises at N+2.
- `unit_ack` in the same cycle as `issue_vld` → BUSY the next cycle.
- `unit_done` at cycle D → `done_vld` at D+1, and the wait bit clears at D+1.
- FSM is in IDLE at D+1. The next issue has `issue_vld` at D+2, giving a one-cycle bubble.
- A request arriving in the same cycle as `unit_done` is accepted normally and arbitrated in the IDLE cycle.
- `unit_done` outside BUSY is ignored.
- `unit_ack` outside ISSUE is ignored.

## Structure
- Shared package `mdu_pkg`:
  - FSM state enum (IDLE, ISSUE, BUSY).
  - `NTHR`, `TID_W = 2`.
  - Op encoding (`OP_MUL = 0`, `OP_DIV = 1`).
- Sub-module `rr_arb4`: 4-way round-robin picker; inputs `req[3:0]` and `ptr[1:0]`, outputs `gnt_vld` and `gnt_tid[1:0]`; purely combinational.
- The pend/kill registers and the FSM live in `mdu_thr_arb`.

## Test plan
- `mul_req = 4'b0001` at cycle 0, ack the same cycle as `issue_vld`, done 5 cycles later.
  - `mul_wait = 0001` at cycle 1; `issue_vld`, `tid 0`, `div 0` at cycle 2; `mul_busy_e = 0001` during cycles 2–7.
  - `done_vld` with `tid 0` one cycle after done; `mul_wait = 0` at the same cycle.
- `div_req = 4'b1111` at cycle 0, each op acked at once and done after 3 cycles.
  - Grants go to tids 0, 1, 2, 3 in order; `div_wait` clears bit by bit.
  - Each issue has the one-cycle bubble after the previous `done_vld`.
- `mul_req[2]` and `div_req[2]` together, then `mul_req[2]` again while pending.
  - `mul_wait = 0100` and `div_wait = 0`.
  - `req_err` pulses twice, one cycle after each offending cycle.
- `thr_flush[1]` during BUSY for tid 1.
  - `mul_wait[1]` clears next cycle.
  - At `unit_done`, no `done_vld`; FSM returns to IDLE and tid 2's pending op issues.
- `unit_ack` withheld for 4 cycles.
  - `issue_vld`, `issue_tid` and `issue_div` stay stable throughout.
  - A new request from another thread is queued, not issued.
- `rst_l` low during BUSY.
  - All outputs are 0 immediately.
  - After release, a fresh `mul_req[3]` issues first with `rr_ptr = 0`.
